// File: rtl/little_alu_driver.sv
// little_alu_driver: buffers (A, B, op) requests in a small FIFO and issues them
// one at a time to a start_op/end_op ALU, returning each result (or a timeout
// error) on a valid/ready response port in command order.
module little_alu_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset_p,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [15:0]                cmd_a,
  input  logic [15:0]                cmd_b,
  input  logic [2:0]                 cmd_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_result,
  output logic [2:0]                 rsp_op,
  output logic                       rsp_err,
  output logic [15:0]                alu_a,
  output logic [15:0]                alu_b,
  output logic [2:0]                 alu_op_sel,
  output logic                       alu_start_op,
  input  logic                       alu_end_op,
  input  logic [31:0]                alu_result,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Entry layout: {op[34:32], b[31:16], a[15:0]}
  logic [34:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [34:0]   head;
  logic          push;
  logic          pop;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [15:0]   alu_a_q, alu_a_d;
  logic [15:0]   alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic          start_q, start_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_result_q, rsp_result_d;
  logic [2:0]    rsp_op_q, rsp_op_d;
  logic          rsp_err_q, rsp_err_d;

  // Full check uses the registered count, so a push never bypasses into the
  // same-cycle pop: the FSM only sees an entry the cycle after it lands.
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == ST_IDLE) && (count_q != '0);
  assign head      = mem[rd_ptr_q];

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
    end
  end

  // FIFO pointer and occupancy update; pointers wrap since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue FSM: pop in IDLE, hold start_op until end_op or timeout, then hold the response.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    start_d      = start_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        start_d = 1'b0;
        if (pop) begin
          alu_a_d  = head[15:0];
          alu_b_d  = head[31:16];
          alu_op_d = head[34:32];
          start_d  = 1'b1;
          tmr_d    = '0;
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        start_d = 1'b1;
        tmr_d   = tmr_q + TW'(1);
        // A completion in the same cycle as the timeout still counts as success.
        if (alu_end_op) begin
          rsp_result_d = alu_result;
          rsp_op_d     = alu_op_q;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          start_d      = 1'b0;
          state_d      = ST_RESP;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_op_d     = alu_op_q;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          start_d      = 1'b0;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        start_d = 1'b0;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        start_d     = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything, including a live operation.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      start_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      start_q      <= start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op_sel   = alu_op_q;
  assign alu_start_op = start_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_op       = rsp_op_q;
  assign rsp_err      = rsp_err_q;
  assign fifo_count   = count_q;
  assign busy         = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_little_alu_driver.sv
// Bench for little_alu_driver: directed commands with hand-computed results,
// a behavioural ALU with per-command latency, and a scoreboard monitor.
module tb_little_alu_driver;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op_sel;
  logic        alu_start_op;
  logic        alu_end_op;
  logic [31:0] alu_result;
  logic        busy;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  int rsp_num = 0;

  logic [35:0] exp_q[$];   // {err, op, result}
  int          lat_q[$];   // ALU latency per issued command

  // ALU model state
  int          wait_cnt = 0;
  int          cur_lat  = 0;
  int          start_len = 0;
  logic [15:0] snap_a, snap_b;
  logic [2:0]  snap_op;

  little_alu_driver #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset_p(reset_p),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_sel(alu_op_sel),
    .alu_start_op(alu_start_op), .alu_end_op(alu_end_op), .alu_result(alu_result),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op);
    case (op)
      3'b001:  return 32'(a) + 32'(b);
      3'b010:  return 32'(a) - 32'(b);
      3'b011:  return 32'(a ^ b);
      3'b100:  return 32'(a) * 32'(b);
      3'b101:  return 32'(a & b);
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural ALU: end_op after the queued latency; operands must stay stable
  // while start_op is high, and start_op must drop right after end_op.
  always @(posedge clk) begin
    #1;
    if (alu_start_op && !reset_p) begin
      if (alu_end_op) check("start_low_after_end", 32'(alu_start_op), 32'h0);
      if (wait_cnt == 0) begin
        cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : 1000;
        snap_a  = alu_a;
        snap_b  = alu_b;
        snap_op = alu_op_sel;
      end else begin
        check("operands_stable", {alu_op_sel, alu_a[12:0], alu_b}, {snap_op, snap_a[12:0], snap_b});
        check("operand_a_stable", 32'(alu_a), 32'(snap_a));
      end
      wait_cnt++;
      if (wait_cnt == cur_lat + 1) begin
        alu_end_op = 1'b1;
        alu_result = alu_fn(alu_a, alu_b, alu_op_sel);
      end else begin
        alu_end_op = 1'b0;
        alu_result = 32'hDEADBEEF;
      end
    end else begin
      if (wait_cnt != 0) start_len = wait_cnt;
      wait_cnt   = 0;
      alu_end_op = 1'b0;
      alu_result = 32'hDEADBEEF;
    end
  end

  // Scoreboard monitor: compare on each handshake, and check the response is held while stalled.
  logic        stall_seen = 1'b0;
  logic [35:0] held;
  always @(negedge clk) begin
    if (reset_p) begin
      stall_seen = 1'b0;
    end else if (rsp_valid) begin
      if (stall_seen) check("rsp_held_stable", {rsp_err, rsp_op, rsp_result[27:0]}, held[31:0]);
      if (rsp_ready) begin
        rsp_num++;
        $display("rsp %0d: result=0x%08h op=%03b err=%0b", rsp_num, rsp_result, rsp_op, rsp_err);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got 0x%08h op=%03b err=%0b with no expected response",
                   rsp_result, rsp_op, rsp_err);
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          if ({rsp_err, rsp_op, rsp_result} !== e) begin
            errors++;
            $display("FAIL rsp_compare: got err=%0b op=%03b result=0x%08h expected err=%0b op=%03b result=0x%08h",
                     rsp_err, rsp_op, rsp_result, e[35], e[34:32], e[31:0]);
          end
        end
        stall_seen = 1'b0;
      end else begin
        held       = {4'h0, rsp_err, rsp_op, rsp_result[27:0]};
        stall_seen = 1'b1;
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  // Offer one command until accepted; record its expected response and ALU latency.
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                      input int lat, input logic [31:0] res, input logic err);
    logic ok;
    ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      ok = cmd_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL push_timeout: cmd_ready=%0b required 1 within 200 cycles", cmd_ready);
    end else begin
      exp_q.push_back({err, op, res});
      lat_q.push_back(lat);
      $display("cmd op=%03b a=0x%04h b=0x%04h", op, a, b);
    end
  endtask

  task automatic wait_rsp_valid();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rsp_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rsp_valid_seen", 32'(seen), 32'h1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) begin done = 1'b1; break; end
    end
    check("drain_done", 32'(done), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_p = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rsp_ready = 1'b1; alu_end_op = 1'b0; alu_result = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 reset_p = 1'b0;

    // Reset state
    check("reset_cmd_ready", 32'(cmd_ready), 32'h1);
    check("reset_fifo_count", 32'(fifo_count), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_start_op", 32'(alu_start_op), 32'h0);

    // 1: add 3+5, ALU answers one cycle after start; latency checks
    push(16'd3, 16'd5, 3'b001, 1, 32'h0000_0008, 1'b0);
    check("t1_start_n1", 32'(alu_start_op), 32'h0);
    @(posedge clk); #1;
    check("t1_start_n2", 32'(alu_start_op), 32'h1);
    @(posedge clk); #1;
    check("t1_rsp_valid_n3", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    check("t1_rsp_valid_n4", 32'(rsp_valid), 32'h1);
    wait_idle();
    check("t1_start_len", 32'(start_len), 32'd2);

    // 2: mul 0xFFFF*0xFFFF, three-cycle ALU
    push(16'hFFFF, 16'hFFFF, 3'b100, 3, 32'hFFFE_0001, 1'b0);
    wait_idle();
    check("t2_start_len", 32'(start_len), 32'd4);

    // 3: hold the FSM in RESP, fill the FIFO, 5th command held until release
    rsp_ready = 1'b0;
    push(16'd1, 16'd2, 3'b000, 0, 32'h0, 1'b0);
    wait_rsp_valid();
    push(16'h1234, 16'h0001, 3'b001, 2, 32'h0000_1235, 1'b0);
    push(16'h0001, 16'h0002, 3'b010, 0, 32'hFFFF_FFFF, 1'b0);
    push(16'hAAAA, 16'h5555, 3'b011, 1, 32'h0000_FFFF, 1'b0);
    push(16'h0100, 16'h0100, 3'b100, 4, 32'h0001_0000, 1'b0);
    fork
      push(16'h0007, 16'h0009, 3'b110, 0, 32'h0, 1'b0);
      begin
        check("t3_full_count", 32'(fifo_count), 32'd4);
        check("t3_full_ready", 32'(cmd_ready), 32'h0);
        repeat (3) begin @(posedge clk); #1; end
        check("t3_fifth_held", 32'(fifo_count), 32'd4);
        rsp_ready = 1'b1;
      end
    join
    wait_idle();

    // 4: ALU never answers -> timeout after 16 ACTIVE cycles; next command issues
    push(16'd9, 16'd4, 3'b010, 1000, 32'h0, 1'b1);
    push(16'h00FF, 16'h0F0F, 3'b011, 0, 32'h0000_0FF0, 1'b0);
    for (int n = 0; n < 100 && exp_q.size() > 1; n++) begin @(posedge clk); #1; end
    check("t4_timeout_len", 32'(start_len), 32'd16);
    wait_idle();

    // 5: consumer stalls 5 cycles; no new issue until the response is taken
    rsp_ready = 1'b0;
    push(16'd10, 16'd3, 3'b010, 2, 32'h0000_0007, 1'b0);
    push(16'hF0F0, 16'hFF00, 3'b101, 1, 32'h0000_F000, 1'b0);
    wait_rsp_valid();
    for (int i = 0; i < 5; i++) begin
      check("t5_result_held", rsp_result, 32'h0000_0007);
      check("t5_no_issue", {alu_start_op, 3'b000, fifo_count}, {1'b0, 3'b000, 3'd1});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_rsp_valid_drop", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    check("t5_next_issue", {alu_start_op, alu_op_sel}, {1'b1, 3'b101});
    wait_idle();

    // 6: reset during ACTIVE with three queued commands
    push(16'd1, 16'd1, 3'b001, 1000, 32'h2, 1'b0);
    push(16'd2, 16'd2, 3'b001, 0, 32'h4, 1'b0);
    push(16'd3, 16'd3, 3'b001, 0, 32'h6, 1'b0);
    push(16'd4, 16'd4, 3'b001, 0, 32'h8, 1'b0);
    check("t6_pre_count", 32'(fifo_count), 32'd3);
    check("t6_pre_start", 32'(alu_start_op), 32'h1);
    reset_p = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk); #1;
    reset_p = 1'b0;
    check("t6_start_op", 32'(alu_start_op), 32'h0);
    check("t6_fifo_count", 32'(fifo_count), 32'h0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t6_cmd_ready", 32'(cmd_ready), 32'h1);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_alu_regs", {alu_a, alu_b}, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("t6_stays_idle", {31'h0, alu_start_op}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/little_alu_driver.md
Name: little_alu_driver

Overview:
- Command-side initiator for the team's start_op/end_op ALU.
- Buffers operation requests (A, B, op) in a small FIFO and issues them one at a time: drives operands, holds start_op until end_op, then captures the 32-bit result.
- Returns each result on a valid/ready response port, in order, with an error flag if the ALU fails to answer in time.
- Sits between a test/sequencer front end and the ALU instance.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, minimum 2.
- TIMEOUT, 16: maximum cycles in ACTIVE without alu_end_op before the operation is aborted with an error.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_p  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals (fifo_count != DEPTH).
- cmd_a  in  16  operand A.
- cmd_b  in  16  operand B.
- cmd_op  in  3  opcode: 000 no_op, 001 add, 010 sub, 011 xor, 100 mul, 101 and, 11x display.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  captured ALU result (0 on error).
- rsp_op  out  3  opcode of the completed command.
- rsp_err  out  1  1 = timeout abort.
- alu_a  out  16  operand A to the ALU.
- alu_b  out  16  operand B to the ALU.
- alu_op_sel  out  3  opcode to the ALU.
- alu_start_op  out  1  request to the ALU.
- alu_end_op  in  1  ALU completion.
- alu_result  in  32  ALU result bus.
- busy  out  1  FSM not in IDLE, or fifo_count != 0.
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset: applies to every register, regardless of state, including mid-operation.
  - FIFO emptied; fifo_count=0; cmd_ready=1.
  - FSM returns to IDLE.
  - alu_start_op=0; alu_a, alu_b, alu_op_sel = 0.
  - rsp_valid=0; rsp_result=0; rsp_op=0; rsp_err=0; busy=0.
- FIFO:
  - Push on cmd_valid && cmd_ready; pop only by the FSM in IDLE.
  - Same-cycle push and pop: count unchanged, both take effect.
  - No bypass: a command pushed in cycle N is poppable at the earliest in cycle N+1.
  - Pointers wrap modulo DEPTH.
  - When full, cmd_ready=0 and cmd_valid is ignored; the data is not stored.
- FSM states: IDLE, ACTIVE, RESP. All outputs are registered.
- IDLE:
  - If fifo_count>0: pop the head, load alu_a/alu_b/alu_op_sel, set alu_start_op=1, clear the timeout counter, go to ACTIVE.
  - Otherwise stay in IDLE.
- ACTIVE:
  - alu_start_op=1; operands and opcode held stable.
  - Counter increments each cycle.
  - If alu_end_op=1: capture alu_result into rsp_result, rsp_op=alu_op_sel, rsp_err=0, rsp_valid=1, alu_start_op=0, go to RESP.
  - Else if counter == TIMEOUT-1: rsp_result=0, rsp_err=1, rsp_valid=1, alu_start_op=0, go to RESP.
  - If alu_end_op and the timeout coincide, alu_end_op wins (rsp_err=0).
- RESP:
  - alu_start_op=0; the response is held stable while rsp_ready=0.
  - On rsp_ready=1: rsp_valid=0 next cycle, go to IDLE.
  - Guarantees at least 2 cycles of alu_start_op low between operations.
- Latency:
  - Command accepted in cycle N → alu_start_op high from N+2.
  - alu_end_op seen in cycle M → rsp_valid high from M+1.
  - Single-cycle ops with a back-to-back ALU: rsp_valid at N+3/N+4, depending on ALU latency.
- alu_end_op is ignored in IDLE and RESP.
- Responses come out strictly in command order; one operation is outstanding at a time.
- Opcodes are passed through unmodified; the driver does not interpret them.

Test Plan:
1. Push add A=3,B=5; ALU model responds 1 cycle after start → rsp_result=0x00000008, rsp_op=001, rsp_err=0; alu_start_op high exactly until end_op.
2. Push mul A=0xFFFF,B=0xFFFF; ALU model asserts end_op 3 cycles after start → rsp_result=0xFFFE0001; operands stable on alu_a/alu_b for all 3 cycles.
3. Push 5 commands back-to-back with DEPTH=4 and the ALU stalled → cmd_ready drops after 4 accepts (fifo_count=4), 5th held; release the ALU → 5 responses in push order, values correct.
4. ALU model never asserts end_op → rsp_valid after TIMEOUT=16 ACTIVE cycles with rsp_err=1, rsp_result=0; the next queued command then issues normally.
5. rsp_ready held low 5 cycles after rsp_valid → rsp_result/rsp_op/rsp_err stable, alu_start_op stays 0, no new issue; rsp_ready=1 → rsp_valid=0 next cycle, next command issues.
6. Assert reset_p for 1 cycle during ACTIVE with 3 queued commands → next cycle alu_start_op=0, fifo_count=0, rsp_valid=0, cmd_ready=1, busy=0.
